// File: rtl/seg7_down_monitor.sv
// seg7_down_monitor
// Receive-side monitor for a common-anode 7-segment digit bus driven by a
// 3-bit down counter. Synchronises and debounces the segment lines, decodes
// each settled pattern back to a digit, and checks that successive digits
// step down by one (7 follows 0). Reports pulses, lock/stall status and
// saturating event counters.
module seg7_down_monitor #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 100_000_000,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       seg_in,
  input  logic             clr,
  output logic [2:0]       digit,
  output logic             digit_valid,
  output logic             bad_pat,
  output logic             seq_err,
  output logic             locked,
  output logic             stall,
  output logic [CNT_W-1:0] step_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bad_cnt
);

  localparam int ST_W = $clog2(STABLE_CYCLES + 1);
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [ST_W-1:0] STABLE_MAX   = ST_W'(STABLE_CYCLES);
  localparam logic [ST_W-1:0] STABLE_HIT   = ST_W'(STABLE_CYCLES - 1);
  localparam logic [TO_W-1:0] TIMEOUT_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [6:0]      BLANK        = 7'h7F;
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED   = 2'd1,
    STALLED  = 2'd2
  } state_t;

  // Segment pattern for each digit, {g,f,e,d,c,b,a}, active-low.
  function automatic logic [6:0] digit_pattern(input int d);
    case (d)
      0:       return 7'b1000000;
      1:       return 7'b1111001;
      2:       return 7'b0100100;
      3:       return 7'b0110000;
      4:       return 7'b0011001;
      5:       return 7'b0010010;
      6:       return 7'b0000010;
      7:       return 7'b1111000;
      default: return BLANK;
    endcase
  endfunction

  state_t            state_reg, state_next;
  logic [6:0]        sync1_reg, sync2_reg;
  logic [6:0]        cand_reg, last_reg;
  logic [ST_W-1:0]   stable_reg, stable_next;
  logic [TO_W-1:0]   timeout_reg, timeout_next;
  logic [2:0]        digit_reg, digit_next;
  logic              valid_reg, valid_next;
  logic              bad_pat_reg, bad_pat_next;
  logic              seq_err_reg, seq_err_next;
  logic [2:0]        cnt_inc;
  logic [CNT_W-1:0]  cnt_reg [3];
  logic [7:0]        match;
  logic              dec_valid;
  logic [2:0]        dec_digit;
  logic [2:0]        prev_digit;
  logic              cand_change;
  logic              accept;

  // Exact-match comparators against the eight legal digit patterns. The
  // synced value is what the candidate becomes this cycle, so decode it.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_match
      assign match[gi] = (sync2_reg == digit_pattern(gi));
    end
  endgenerate

  // One-hot match to digit; at most one bit can be set.
  always_comb begin
    dec_valid = |match;
    dec_digit = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (match[i]) dec_digit = 3'(i);
    end
  end

  // Stability counter: restart on any change, saturate once settled.
  always_comb begin
    cand_change = (sync2_reg != cand_reg);
    if (cand_change)
      stable_next = '0;
    else if (stable_reg == STABLE_MAX)
      stable_next = stable_reg;
    else
      stable_next = stable_reg + 1'b1;
  end

  // A pattern is accepted once, on the cycle it first counts as settled,
  // and only if it differs from the pattern accepted before it.
  assign accept     = (stable_next == STABLE_HIT) && (sync2_reg != last_reg);
  assign prev_digit = digit_reg - 3'd1;

  // Lock/stall state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= UNLOCKED;
    else        state_reg <= state_next;
  end

  // Next state, sequence check, event pulses and timeout counter.
  always_comb begin
    state_next   = state_reg;
    timeout_next = timeout_reg;
    digit_next   = digit_reg;
    valid_next   = 1'b0;
    bad_pat_next = 1'b0;
    seq_err_next = 1'b0;
    cnt_inc      = 3'b000;
    case (state_reg)
      UNLOCKED: timeout_next = '0;
      LOCKED: begin
        if (timeout_reg == TIMEOUT_LAST) state_next = STALLED;
        else                             timeout_next = timeout_reg + 1'b1;
      end
      STALLED:  timeout_next = timeout_reg;
      default:  state_next = UNLOCKED;
    endcase
    if (accept) begin
      timeout_next = '0;
      if (dec_valid) begin
        valid_next = 1'b1;
        digit_next = dec_digit;
        state_next = LOCKED;
        // The first digit after losing lock only establishes the base.
        if (state_reg != UNLOCKED) begin
          if (dec_digit == prev_digit) begin
            cnt_inc[0] = 1'b1;
          end else begin
            seq_err_next = 1'b1;
            cnt_inc[1]   = 1'b1;
          end
        end
      end else begin
        bad_pat_next = 1'b1;
        cnt_inc[2]   = 1'b1;
        state_next   = UNLOCKED;
      end
    end
  end

  // Synchroniser, debounce state, accepted pattern and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_reg   <= BLANK;
      sync2_reg   <= BLANK;
      cand_reg    <= BLANK;
      last_reg    <= BLANK;
      stable_reg  <= '0;
      timeout_reg <= '0;
      digit_reg   <= 3'd0;
      valid_reg   <= 1'b0;
      bad_pat_reg <= 1'b0;
      seq_err_reg <= 1'b0;
    end else begin
      sync1_reg   <= seg_in;
      sync2_reg   <= sync1_reg;
      cand_reg    <= sync2_reg;
      last_reg    <= accept ? sync2_reg : last_reg;
      stable_reg  <= stable_next;
      timeout_reg <= timeout_next;
      digit_reg   <= digit_next;
      valid_reg   <= valid_next;
      bad_pat_reg <= bad_pat_next;
      seq_err_reg <= seq_err_next;
    end
  end

  // Saturating event counters: 0 = steps, 1 = sequence errors, 2 = bad patterns.
  // clr takes priority over an increment in the same cycle.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)
          cnt_reg[gi] <= '0;
        else if (clr)
          cnt_reg[gi] <= '0;
        else if (cnt_inc[gi] && (cnt_reg[gi] != CNT_MAX))
          cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
      end
    end
  endgenerate

  assign digit       = digit_reg;
  assign digit_valid = valid_reg;
  assign bad_pat     = bad_pat_reg;
  assign seq_err     = seq_err_reg;
  assign locked      = (state_reg == LOCKED);
  assign stall       = (state_reg == STALLED);
  assign step_cnt    = cnt_reg[0];
  assign err_cnt     = cnt_reg[1];
  assign bad_cnt     = cnt_reg[2];

endmodule
